inference_sequencer: RTL and testbench

Sequences one inference run of the neural-network datapath behind the SPI register bank. On a start pulse it streams the 121 image bytes held in the write registers to the network core over a valid/ready handshake, waits for the core's result, and latches the 4-bit class prediction that is returned to the host through the read register. It sits between the register bank and the network core and is the only master of the core's pixel input.

---
 rtl/inference_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_inference_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//
// Runs one inference of the neural-network core. When start is accepted, the
// block streams the NPIX image bytes from the register bank to the core over a
// valid/ready handshake. It then waits for the core's result and latches the
// class prediction for the host read register. If the core does not answer
// within TIMEOUT cycles, the run ends with an error.
//
// Optional feature, enabled by the macro SEQ_SNAPSHOT_EN:
//   When defined, the image is copied into an internal buffer on an accepted
//   start. Register writes during a run then cannot disturb the streamed
//   image. When undefined, pixels are read live from pix_flat.
//
// Parameters
//   NPIX     pixels per image (also the number of write registers)
//   WORD     pixel width in bits
//   CLASS_W  prediction width in bits
//   TIMEOUT  maximum cycles spent waiting for the core's result (>= 2)
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset; aborts any run without a done
//   start      one-cycle request to run an inference (ignored while busy)
//   pix_flat   image from the register bank, pixel i at [i*WORD +: WORD]
//   pix_data   pixel presented to the core (0 when not streaming)
//   pix_valid  pix_data is valid
//   pix_last   current beat carries pixel NPIX-1
//   pix_ready  core accepts the current beat
//   nn_done    core result valid pulse
//   nn_class   core result, sampled only with nn_done
//   pred       latched prediction (all ones after a timeout)
//   busy       a run is in progress
//   done       one-cycle pulse at the end of a run
//   err        last run timed out; sticky until the next accepted start
// -----------------------------------------------------------------------------
module inference_sequencer #(
  parameter int NPIX    = 121,
  parameter int WORD    = 8,
  parameter int CLASS_W = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NPIX*WORD-1:0] pix_flat,
  output logic [WORD-1:0]      pix_data,
  output logic                 pix_valid,
  output logic                 pix_last,
  input  logic                 pix_ready,
  input  logic                 nn_done,
  input  logic [CLASS_W-1:0]   nn_class,
  output logic [CLASS_W-1:0]   pred,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [CLASS_W-1:0] pred_next;
  logic               err_next;
  logic               done_next;
  logic               busy_next;
  logic               load_image;
  logic [WORD-1:0]    cur_pix;

  // Pixel source for the current index. The select is written as an explicit
  // compare-per-entry mux. Index codes beyond NPIX-1 can never be reached,
  // and they simply fall through to zero.
`ifdef SEQ_SNAPSHOT_EN
  logic [WORD-1:0] snap [NPIX];

  // Image buffer, captured on the same cycle the run is accepted so the whole
  // stream comes from one consistent copy of the register bank.
  always_ff @(posedge clk) begin
    if (load_image) begin
      for (int i = 0; i < NPIX; i++) begin
        snap[i] <= pix_flat[i*WORD +: WORD];
      end
    end
  end

  always_comb begin
    cur_pix = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (idx == IDX_W'(i)) cur_pix = snap[i];
    end
  end
`else
  always_comb begin
    cur_pix = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (idx == IDX_W'(i)) cur_pix = pix_flat[i*WORD +: WORD];
    end
  end
`endif

  // Next-state and next-register logic. done only ever pulses for one cycle.
  // In WAIT, nn_done is tested before the timeout limit, so a result that
  // arrives on the very last tick still counts as success.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    timer_next = timer;
    pred_next  = pred;
    err_next   = err;
    done_next  = 1'b0;
    load_image = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_STREAM;
          idx_next   = '0;
          err_next   = 1'b0;
          load_image = 1'b1;
        end
      end

      S_STREAM: begin
        if (pix_ready) begin
          if (idx == LAST_IDX) begin
            state_next = S_WAIT;
            timer_next = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (nn_done) begin
          pred_next  = nn_class;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (timer == LAST_TICK) begin
          pred_next  = '1;
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // State and output registers. Reset clears every visible output, including
  // the retained prediction and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      timer <= '0;
      pred  <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      timer <= timer_next;
      pred  <= pred_next;
      err   <= err_next;
      done  <= done_next;
      busy  <= busy_next;
    end
  end

  // Stream outputs come from the registered state and index only. The one
  // exception is the live image path when no snapshot buffer is built.
  always_comb begin
    pix_valid = (state == S_STREAM);
    pix_data  = pix_valid ? cur_pix : '0;
    pix_last  = pix_valid && (idx == LAST_IDX);
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inference_sequencer
//
// Directed bench for inference_sequencer with TIMEOUT=16. A run-level model
// tracks how many beats have been delivered, how long the result has been
// awaited, and the latched prediction/error. Every cycle the outputs are
// compared against what those quantities imply. Directed scenarios add
// hand-computed literal expectations for the nominal run, backpressure,
// timeout, ignored inputs, reset mid-run and the snapshot option.
// -----------------------------------------------------------------------------
module tb_inference_sequencer;

  localparam int NPIX    = 121;
  localparam int WORD    = 8;
  localparam int CLASS_W = 4;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NPIX*WORD-1:0] pix_flat;
  logic [WORD-1:0]      pix_data;
  logic                 pix_valid;
  logic                 pix_last;
  logic                 pix_ready;
  logic                 nn_done;
  logic [CLASS_W-1:0]   nn_class;
  logic [CLASS_W-1:0]   pred;
  logic                 busy;
  logic                 done;
  logic                 err;

  int checks = 0;
  int errors = 0;

  inference_sequencer #(
    .NPIX(NPIX), .WORD(WORD), .CLASS_W(CLASS_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_flat(pix_flat),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last),
    .pix_ready(pix_ready), .nn_done(nn_done), .nn_class(nn_class),
    .pred(pred), .busy(busy), .done(done), .err(err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [WORD-1:0] pixel_of(input int i);
    return pix_flat[i*WORD +: WORD];
  endfunction

  // ---------------------------------------------------------------------------
  // Run-level model: a run is either absent or has delivered m_sent beats.
  // Once all beats are delivered, m_age counts the cycles spent awaiting the
  // result. Inputs are read at the rising edge. They change 2ns after it.
  // ---------------------------------------------------------------------------
  bit               m_live = 1'b0;
  bit               m_run;
  int               m_sent;
  int               m_age;
  logic [CLASS_W-1:0] m_pred;
  bit               m_err;
  bit               m_done;
`ifdef SEQ_SNAPSHOT_EN
  logic [WORD-1:0]  m_snap [NPIX];
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1;
      m_run  = 1'b0;
      m_sent = 0;
      m_age  = 0;
      m_pred = '0;
      m_err  = 1'b0;
      m_done = 1'b0;
    end else if (m_live) begin
      m_done = 1'b0;
      if (!m_run) begin
        if (start) begin
          m_run  = 1'b1;
          m_sent = 0;
          m_age  = 0;
          m_err  = 1'b0;
`ifdef SEQ_SNAPSHOT_EN
          for (int i = 0; i < NPIX; i++) m_snap[i] = pixel_of(i);
`endif
        end
      end else if (m_sent < NPIX) begin
        if (pix_ready) m_sent++;
      end else if (nn_done) begin
        m_pred = nn_class;
        m_done = 1'b1;
        m_run  = 1'b0;
      end else if (m_age == TIMEOUT - 1) begin
        m_pred = '1;
        m_err  = 1'b1;
        m_done = 1'b1;
        m_run  = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  // Compare process, on the falling edge so the outputs have settled.
  always @(negedge clk) begin
    if (m_live) begin
      automatic bit              e_valid = m_run && (m_sent < NPIX);
      automatic logic [WORD-1:0] e_data  = '0;
      if (e_valid) begin
`ifdef SEQ_SNAPSHOT_EN
        e_data = m_snap[m_sent];
`else
        e_data = pixel_of(m_sent);
`endif
      end
      checkOutput("mdl_busy",  busy,      m_run);
      checkOutput("mdl_valid", pix_valid, e_valid);
      checkOutput("mdl_data",  pix_data,  e_data);
      checkOutput("mdl_last",  pix_last,  e_valid && (m_sent == NPIX - 1));
      checkOutput("mdl_pred",  pred,      m_pred);
      checkOutput("mdl_err",   err,       m_err);
      checkOutput("mdl_done",  done,      m_done);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit s, input bit r, input bit d,
                               input logic [CLASS_W-1:0] c);
    start     = s;
    pix_ready = r;
    nn_done   = d;
    nn_class  = c;
  endtask

  task automatic load_image();
    for (int i = 0; i < NPIX; i++) pix_flat[i*WORD +: WORD] = WORD'(i + 1);
  endtask

  // Streams with pix_ready high from relative cycle 'from' through 'to'.
  // At each cycle it checks that the beat carries pixel (cycle-1), i.e.
  // data value == cycle.
  task automatic stream_cycles(input int from, input int to, input string tag);
    for (int c = from; c <= to; c++) begin
      step();
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput({tag, "_data"}, pix_data, c);
    end
  endtask

  initial begin
    int got;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    load_image();
    step();
    step();

    // Reset state
    checkOutput("rst_busy",  busy,      1'b0);
    checkOutput("rst_valid", pix_valid, 1'b0);
    checkOutput("rst_data",  pix_data,  8'h00);
    checkOutput("rst_pred",  pred,      4'h0);
    checkOutput("rst_err",   err,       1'b0);
    checkOutput("rst_done",  done,      1'b0);
    rst = 1'b0;
    step();

    // Nominal run: start in cycle 0, nn_done with class 7 in cycle 130
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int c = 1; c <= NPIX; c++) begin
      step();
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("nom_valid", pix_valid, 1'b1);
      checkOutput("nom_data",  pix_data,  c);
      checkOutput("nom_last",  pix_last,  c == NPIX);
    end
    for (int c = NPIX + 1; c <= 130; c++) begin
      step();
      applyStimulus(1'b0, 1'b1, c == 130, (c == 130) ? 4'd7 : 4'd0);
      checkOutput("nom_wait_busy",  busy,      1'b1);
      checkOutput("nom_wait_valid", pix_valid, 1'b0);
    end
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("nom_done", done, 1'b1);
    checkOutput("nom_pred", pred, 4'd7);
    checkOutput("nom_err",  err,  1'b0);
    checkOutput("nom_busy", busy, 1'b0);
    step();
    checkOutput("nom_done_pulse", done, 1'b0);
    checkOutput("nom_pred_hold",  pred, 4'd7);

    // Backpressure: pix_ready alternates every cycle
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    got = 0;
    for (int k = 1; k < 600 && got < NPIX; k++) begin
      step();
      applyStimulus(1'b0, k[0], 1'b0, '0);
      if (pix_valid && k[0]) begin
        checkOutput("bp_order", pix_data, got + 1);
        got++;
      end
    end
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5);
    checkOutput("bp_count",     got,       NPIX);
    checkOutput("bp_end_valid", pix_valid, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("bp_done", done, 1'b1);
    checkOutput("bp_pred", pred, 4'd5);
    step();

    // Timeout: WAIT entered at relative cycle 122, error declared at 138
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    stream_cycles(1, NPIX, "to");
    for (int c = NPIX + 1; c < NPIX + 1 + TIMEOUT; c++) begin
      step();
      checkOutput("to_no_done", done, 1'b0);
    end
    step();
    checkOutput("to_done", done, 1'b1);
    checkOutput("to_err",  err,  1'b1);
    checkOutput("to_pred", pred, 4'hF);
    // Back-to-back start in the cycle done is high
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("b2b_err_clear", err,      1'b0);
    checkOutput("b2b_busy",      busy,     1'b1);
    checkOutput("b2b_data",      pix_data, 8'd1);
    checkOutput("b2b_pred_keep", pred,     4'hF);

    // Ignored inputs: start and nn_done during STREAM at relative cycle 10
    stream_cycles(2, 9, "ign");
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd9);
    checkOutput("ign_data10", pix_data, 8'd10);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("ign_no_restart", pix_data, 8'd11);
    checkOutput("ign_pred_keep",  pred,     4'hF);
    stream_cycles(12, NPIX, "ign");
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd3);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("ign_done", done, 1'b1);
    checkOutput("ign_pred", pred, 4'd3);
    step();

    // Reset mid-run at beat 60
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    stream_cycles(1, 60, "mr");
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mr_busy",  busy,      1'b0);
    checkOutput("mr_valid", pix_valid, 1'b0);
    checkOutput("mr_data",  pix_data,  8'h00);
    checkOutput("mr_last",  pix_last,  1'b0);
    checkOutput("mr_pred",  pred,      4'h0);
    checkOutput("mr_err",   err,       1'b0);
    checkOutput("mr_done",  done,      1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("mr_no_done", done, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    stream_cycles(1, NPIX, "mr2");
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd2);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("mr2_pred", pred, 4'd2);
    step();

    // Snapshot: rewrite pixel 100 during beat 50
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    stream_cycles(1, 50, "sn");
    pix_flat[100*WORD +: WORD] = 8'hAA;
    stream_cycles(51, 100, "sn");
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
`ifdef SEQ_SNAPSHOT_EN
    checkOutput("sn_pix100", pix_data, 8'd101);
`else
    checkOutput("sn_pix100", pix_data, 8'hAA);
`endif
    stream_cycles(102, NPIX, "sn");
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd1);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("sn_pred", pred, 4'd1);
    load_image();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
